// File: rtl/fir_ctrl_pkg.sv
// Shared encodings for the polyphase transmit FIR control path.
// State codes and the phase values with fixed meaning to the FIR/PRBS datapath.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int N_PHASES = 4;
    localparam int PHASE_W  = $clog2(N_PHASES);

    localparam logic [PHASE_W-1:0] PHASE_SHIFT = 2'b01;
    localparam logic [PHASE_W-1:0] PHASE_LAST  = 2'b11;

endpackage

// File: rtl/rate_tick_gen.sv
// Sample-rate divider: counts 0..rate_q and emits one tick per sample period.
// The period is latched on load so that run-time changes to the input are ignored.
module rate_tick_gen #(
    parameter int NB_DIV = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic              run,
    input  logic [NB_DIV-1:0] rate_div,
    output logic              tick
);

    logic [NB_DIV-1:0] div_cnt;
    logic [NB_DIV-1:0] rate_q;

    assign tick = run & (div_cnt == rate_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt <= '0;
            rate_q  <= '0;
        end else begin
            if (load) begin
                rate_q <= rate_div;
            end
            if (clear || tick) begin
                div_cnt <= '0;
            end else if (run) begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_tx_sequencer.sv
// Sequencer for the 4-phase polyphase I/Q transmit FIR: sample tick, phase counter,
// PRBS symbol strobe, fill tracking, output-valid flag and downsampler strobe.
//
// state | meaning
// IDLE  | stopped; phase, divider and fill count held at zero
// FILL  | ticking, waiting for NBAUDS symbols to fill the FIR shift register
// RUN   | FIR output valid, free-running
// DRAIN | run dropped; finish the current symbol, then stop
module fir_tx_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int NB_DIV  = 8,
    parameter int NBAUDS  = 6,
    parameter int NB_FILL = 3
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [NB_DIV-1:0] i_rate_div,
    input  logic [1:0]        i_phase_sel,
    output logic [2:0]        o_counter_mux,
    output logic              o_fir_enable,
    output logic              o_prbs_enable,
    output logic              o_fir_valid,
    output logic              o_ds_strobe,
    output logic              o_busy
);

    localparam logic [NB_FILL-1:0] FILL_LAST = NB_FILL'(NBAUDS - 1);

    state_t               state;
    logic [PHASE_W-1:0]   phase;
    logic [NB_FILL-1:0]   fill_cnt;
    logic                 active;
    logic                 tick;
    logic                 abort;
    logic                 shift_strobe;
    logic                 last_tick;

    assign active       = (state != IDLE);
    assign abort        = (state == FILL) && !i_enable;
    assign shift_strobe = tick && (phase == PHASE_SHIFT);
    assign last_tick    = tick && (phase == PHASE_LAST);

    rate_tick_gen #(
        .NB_DIV (NB_DIV)
    ) u_rate_tick_gen (
        .clock    (clock),
        .reset    (i_reset),
        .clear    ((state == IDLE) || abort),
        .load     ((state == IDLE) && i_enable),
        .run      (active),
        .rate_div (i_rate_div),
        .tick     (tick)
    );

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state    <= IDLE;
            phase    <= '0;
            fill_cnt <= '0;
        end else begin
            if ((state == IDLE) || abort) begin
                phase <= '0;
            end else if (tick) begin
                phase <= phase + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    fill_cnt <= '0;
                    if (i_enable) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    // Abort wins over a fill-completing strobe in the same cycle.
                    if (!i_enable) begin
                        state    <= IDLE;
                        fill_cnt <= '0;
                    end else if (shift_strobe) begin
                        if (fill_cnt == FILL_LAST) begin
                            state    <= RUN;
                            fill_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!i_enable) begin
                        state <= last_tick ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_tick) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy        = active;
    assign o_fir_enable  = tick;
    assign o_prbs_enable = shift_strobe;
    assign o_ds_strobe   = tick && (state == RUN) && (phase == i_phase_sel);
    assign o_fir_valid   = (state == RUN) || (state == DRAIN);
    assign o_counter_mux = active ? {1'b0, phase} : 3'b000;

endmodule

// File: tb/tb_fir_tx_sequencer.sv
// Directed self-checking bench for fir_tx_sequencer with hand-derived timing.
module tb_fir_tx_sequencer;

    logic       clock;
    logic       i_reset;
    logic       i_enable;
    logic [7:0] i_rate_div;
    logic [1:0] i_phase_sel;
    logic [2:0] o_counter_mux;
    logic       o_fir_enable;
    logic       o_prbs_enable;
    logic       o_fir_valid;
    logic       o_ds_strobe;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    fir_tx_sequencer dut (
        .clock         (clock),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_rate_div    (i_rate_div),
        .i_phase_sel   (i_phase_sel),
        .o_counter_mux (o_counter_mux),
        .o_fir_enable  (o_fir_enable),
        .o_prbs_enable (o_prbs_enable),
        .o_fir_valid   (o_fir_valid),
        .o_ds_strobe   (o_ds_strobe),
        .o_busy        (o_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_mux"},   8'(o_counter_mux), 8'd0);
        chk({tag, "_fir"},   8'(o_fir_enable),  8'd0);
        chk({tag, "_prbs"},  8'(o_prbs_enable), 8'd0);
        chk({tag, "_valid"}, 8'(o_fir_valid),   8'd0);
        chk({tag, "_ds"},    8'(o_ds_strobe),   8'd0);
        chk({tag, "_busy"},  8'(o_busy),        8'd0);
    endtask

    // rate 0, enable already driven high: j counts edges after the enabling edge
    task automatic fill_rate0(input string tag);
        for (int j = 0; j <= 22; j++) begin
            step();
            chk({tag, "_fir"},   8'(o_fir_enable), 8'd1);
            chk({tag, "_prbs"},  8'(o_prbs_enable), 8'((j % 4 == 1) && (j <= 21)));
            chk({tag, "_valid"}, 8'(o_fir_valid), 8'(j == 22));
            chk({tag, "_ds"},    8'(o_ds_strobe), 8'd0);
            if (j == 22) chk({tag, "_mux_run"}, 8'(o_counter_mux), 8'd2);
        end
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            step();
            if (!o_busy) done = 1'b1;
        end
        chk({tag, "_idle_reached"}, 8'(done), 8'd1);
    endtask

    initial begin
        logic [1:0] ph;
        int hits;

        i_reset     = 1'b1;
        i_enable    = 1'b0;
        i_rate_div  = 8'd0;
        i_phase_sel = 2'd0;
        repeat (3) step();
        chk_idle("por");
        i_reset = 1'b0;
        step();
        chk_idle("por_rel");

        // rate 0 fill
        i_enable = 1'b1;
        fill_rate0("fill0");

        // downsampler phase sweep in RUN, phase is 10 now
        ph = 2'd2;
        for (int s = 0; s < 4; s++) begin
            i_phase_sel = 2'(s);
            hits = 0;
            for (int n = 0; n < 4; n++) begin
                step();
                ph = ph + 2'd1;
                chk("sweep_mux", 8'(o_counter_mux), 8'(ph));
                chk("sweep_ds", 8'(o_ds_strobe), 8'(ph == 2'(s)));
                if (o_ds_strobe) hits++;
            end
            chk("sweep_hits", 8'(hits), 8'd1);
        end

        // synchronous reset mid-RUN
        i_reset  = 1'b1;
        i_enable = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            chk_idle("rst_hold");
        end
        i_reset = 1'b0;
        step();
        chk_idle("rst_rel");

        // drain from phase 00
        i_enable = 1'b1;
        fill_rate0("fill_d");
        step();
        step();
        chk("drain_pre_mux", 8'(o_counter_mux), 8'd0);
        i_enable = 1'b0;
        step();
        chk("drain_busy", 8'(o_busy), 8'd1);
        chk("drain_valid1", 8'(o_fir_valid), 8'd1);
        chk("drain_mux1", 8'(o_counter_mux), 8'd1);
        chk("drain_prbs1", 8'(o_prbs_enable), 8'd1);
        chk("drain_ds_gated", 8'(o_ds_strobe), 8'd0);
        i_enable = 1'b1;
        step();
        chk("drain_mux2", 8'(o_counter_mux), 8'd2);
        chk("drain_prbs2", 8'(o_prbs_enable), 8'd0);
        chk("drain_valid2", 8'(o_fir_valid), 8'd1);
        step();
        chk("drain_mux3", 8'(o_counter_mux), 8'd3);
        chk("drain_valid3", 8'(o_fir_valid), 8'd1);
        step();
        chk_idle("drain_end");
        step();
        chk("refill_busy", 8'(o_busy), 8'd1);
        chk("refill_valid", 8'(o_fir_valid), 8'd0);
        chk("refill_mux", 8'(o_counter_mux), 8'd0);

        // abort after 3 strobes (refill entered at j=0 above)
        for (int j = 1; j <= 9; j++) begin
            step();
            chk("abort_prbs", 8'(o_prbs_enable), 8'(j % 4 == 1));
        end
        i_enable = 1'b0;
        step();
        chk_idle("abort");
        i_enable = 1'b1;
        fill_rate0("fill_after_abort");

        // rate 3
        i_enable = 1'b0;
        wait_idle("to_rate3");
        i_rate_div = 8'd3;
        i_enable   = 1'b1;
        for (int j = 0; j <= 88; j++) begin
            step();
            ph = 2'((j / 4) % 4);
            chk("r3_fir", 8'(o_fir_enable), 8'(j % 4 == 3));
            chk("r3_mux", 8'(o_counter_mux), 8'(ph));
            chk("r3_prbs", 8'(o_prbs_enable), 8'((j % 4 == 3) && (ph == 2'd1)));
            chk("r3_valid", 8'(o_fir_valid), 8'(j == 88));
        end
        i_rate_div = 8'd0;
        for (int j = 89; j <= 104; j++) begin
            step();
            chk("r3_hold_fir", 8'(o_fir_enable), 8'(j % 4 == 3));
            chk("r3_hold_mux", 8'(o_counter_mux), 8'((j / 4) % 4));
            chk("r3_hold_valid", 8'(o_fir_valid), 8'd1);
        end

        i_enable = 1'b0;
        wait_idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
